// File: rtl/door_beam_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : door_beam_decoder
//  Description : Doorway break-beam front end. Synchronises and debounces the
//                outer (beam_a) and inner (beam_b) beams, then decodes the
//                order they are broken into single-cycle ent/exit pulses.
//                Illegal orderings and stalled crossings raise fault.
//                Build option DOOR_BEAM_FAULT_STICKY_EN: when defined, fault
//                latches on the first fault event until rst_n is asserted;
//                when undefined, fault is a one-cycle pulse per event.
//  Revision    : 1.0 - initial release
// ============================================================================
module door_beam_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic beam_a,
    input  logic beam_b,
    output logic ent,
    output logic exit,
    output logic busy,
    output logic fault
);

    // Counters compare against "one before the limit" so the level or state
    // changes on the cycle the count would reach the limit.
    localparam logic [7:0]  c_DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_IN_A   = 3'd1;
    localparam logic [2:0] S_IN_AB  = 3'd2;
    localparam logic [2:0] S_IN_B   = 3'd3;
    localparam logic [2:0] S_OUT_B  = 3'd4;
    localparam logic [2:0] S_OUT_AB = 3'd5;
    localparam logic [2:0] S_OUT_A  = 3'd6;
    localparam logic [2:0] S_ABORT  = 3'd7;

    // Bit 1 carries the outer beam, bit 0 the inner beam, so the pair reads {a,b}.
    logic [1:0] w_raw;
    logic [1:0] w_pair;
    assign w_raw = {beam_a, beam_b};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_beam
            logic       r_meta;
            logic       r_sync;
            logic       r_deb;
            logic [7:0] r_cnt;

            // Two-flop synchroniser followed by a hold-time debounce counter.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_meta <= 1'b0;
                    r_sync <= 1'b0;
                    r_deb  <= 1'b0;
                    r_cnt  <= 8'd0;
                end else begin
                    r_meta <= w_raw[gi];
                    r_sync <= r_meta;
                    if (r_sync == r_deb) begin
                        r_cnt <= 8'd0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_deb <= r_sync;
                        r_cnt <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            end

            assign w_pair[gi] = r_deb;
        end
    endgenerate

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [1:0]  r_pair_q;
    logic [15:0] r_tcnt;
    logic        w_crossing;
    logic        w_timeout;
    logic        w_ent_ev;
    logic        w_exit_ev;
    logic        w_fault_ev;
    logic        r_ent;
    logic        r_exit;
    logic        r_busy;
    logic        r_fault;

    assign w_crossing = (r_state != S_IDLE) && (r_state != S_ABORT);
    assign w_timeout  = w_crossing && (r_tcnt == c_TO_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode of the debounced pair; a timeout overrides any move.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: case (w_pair)
                2'b10:   w_next = S_IN_A;
                2'b01:   w_next = S_OUT_B;
                2'b11:   w_next = S_ABORT;
                default: w_next = S_IDLE;
            endcase
            S_IN_A: case (w_pair)
                2'b11:   w_next = S_IN_AB;
                2'b00:   w_next = S_IDLE;
                2'b01:   w_next = S_ABORT;
                default: w_next = S_IN_A;
            endcase
            S_IN_AB: case (w_pair)
                2'b01:   w_next = S_IN_B;
                2'b10:   w_next = S_IN_A;
                2'b00:   w_next = S_ABORT;
                default: w_next = S_IN_AB;
            endcase
            S_IN_B: case (w_pair)
                2'b00:   w_next = S_IDLE;
                2'b11:   w_next = S_IN_AB;
                2'b10:   w_next = S_ABORT;
                default: w_next = S_IN_B;
            endcase
            S_OUT_B: case (w_pair)
                2'b11:   w_next = S_OUT_AB;
                2'b00:   w_next = S_IDLE;
                2'b10:   w_next = S_ABORT;
                default: w_next = S_OUT_B;
            endcase
            S_OUT_AB: case (w_pair)
                2'b10:   w_next = S_OUT_A;
                2'b01:   w_next = S_OUT_B;
                2'b00:   w_next = S_ABORT;
                default: w_next = S_OUT_AB;
            endcase
            S_OUT_A: case (w_pair)
                2'b00:   w_next = S_IDLE;
                2'b11:   w_next = S_OUT_AB;
                2'b01:   w_next = S_ABORT;
                default: w_next = S_OUT_A;
            endcase
            default: begin
                if (w_pair == 2'b00) begin
                    w_next = S_IDLE;
                end
            end
        endcase
        if (w_timeout) begin
            w_next = S_ABORT;
        end
    end

    // Output events: every entry into ABORT is a fault, whatever caused it.
    always_comb begin
        w_ent_ev   = (r_state == S_IN_B)  && (w_next == S_IDLE);
        w_exit_ev  = (r_state == S_OUT_A) && (w_next == S_IDLE);
        w_fault_ev = (r_state != S_ABORT) && (w_next == S_ABORT);
    end

    // Stall timer: restarts on any state or pair movement, runs only mid-crossing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt   <= 16'd0;
            r_pair_q <= 2'b00;
        end else begin
            r_pair_q <= w_pair;
            if (!w_crossing || (w_next != r_state) || (w_pair != r_pair_q)) begin
                r_tcnt <= 16'd0;
            end else begin
                r_tcnt <= r_tcnt + 16'd1;
            end
        end
    end

    // Registered outputs; busy mirrors the state being entered on this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ent   <= 1'b0;
            r_exit  <= 1'b0;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_ent  <= w_ent_ev;
            r_exit <= w_exit_ev;
            r_busy <= (w_next != S_IDLE);
`ifdef DOOR_BEAM_FAULT_STICKY_EN
            r_fault <= r_fault | w_fault_ev;
`else
            r_fault <= w_fault_ev;
`endif
        end
    end

    assign ent   = r_ent;
    assign exit  = r_exit;
    assign busy  = r_busy;
    assign fault = r_fault;

endmodule
`default_nettype wire
